// File: rtl/ssub_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared-subtractor arbiter and its consumer.
interface ssub_arbiter_if #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]           req;
  logic [NREQ*DATAWIDTH-1:0] a_in;
  logic [NREQ*DATAWIDTH-1:0] b_in;
  logic [NREQ-1:0]           ack;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATAWIDTH-1:0]      diff_out;
  logic                      ovf;
  logic [IDW-1:0]            rsp_id;
  logic                      busy;

  modport slave (
    input  req, a_in, b_in, rsp_ready,
    output ack, rsp_valid, diff_out, ovf, rsp_id, busy
  );

  modport master (
    output req, a_in, b_in, rsp_ready,
    input  ack, rsp_valid, diff_out, ovf, rsp_id, busy
  );
endinterface

// File: rtl/ssub_arbiter.sv
// Round-robin arbiter sharing one registered signed subtractor (a - b) among NREQ requesters.
// Optional macro SSUB_ARB_SAT_EN: saturate diff_out on signed overflow instead of wrapping.
module ssub_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  ssub_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MSB = DATAWIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic [NREQ-1:0]      r_ack;
  logic                 r_rsp_valid;
  logic                 r_ovf;
  logic                 r_busy;
  logic [DATAWIDTH-1:0] r_a;
  logic [DATAWIDTH-1:0] r_b;
  logic [DATAWIDTH-1:0] r_diff;
  logic [IDW-1:0]       r_id;
  logic [IDW-1:0]       r_last_id;
  logic [IDW-1:0]       r_rsp_id;

  logic                 w_found;
  logic [IDW-1:0]       w_win;
  logic [DATAWIDTH-1:0] w_sub;
  logic                 w_ovf;
  logic [DATAWIDTH-1:0] w_res;

  // Search starts one past the last served requester and wraps upward.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last_id) + k) % NREQ;
      if (!w_found && bus.req[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  assign w_sub = r_a - r_b;
  assign w_ovf = (r_a[MSB] != r_b[MSB]) && (w_sub[MSB] != r_a[MSB]);

`ifdef SSUB_ARB_SAT_EN
  assign w_res = !w_ovf   ? w_sub :
                 r_a[MSB] ? {1'b1, {(DATAWIDTH-1){1'b0}}} :
                            {1'b0, {(DATAWIDTH-1){1'b1}}};
`else
  assign w_res = w_sub;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_ack       <= '0;
      r_rsp_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_id        <= '0;
      r_last_id   <= IDW'(NREQ - 1);
      r_rsp_id    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a     <= bus.a_in[w_win*DATAWIDTH +: DATAWIDTH];
            r_b     <= bus.b_in[w_win*DATAWIDTH +: DATAWIDTH];
            r_id    <= w_win;
            r_ack   <= NREQ'(1) << w_win;
            r_state <= S_EXEC;
            r_busy  <= 1'b1;
          end
        end
        S_EXEC: begin
          r_diff      <= w_res;
          r_ovf       <= w_ovf;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_last_id   <= r_id;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.diff_out  = r_diff;
  assign bus.ovf       = r_ovf;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ssub_arbiter.sv
// Self-checking bench for ssub_arbiter: reset cases, directed vector table, round-robin and random traffic.
module tb_ssub_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;

  logic Clk;
  logic Rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_last = NR - 1;

  ssub_arbiter_if #(.DATAWIDTH(DW), .NREQ(NR)) bus ();
  ssub_arbiter #(.DATAWIDTH(DW), .NREQ(NR)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] a;
    logic [7:0] b;
    int         stall;
    logic [3:0] e_ack;
    logic [7:0] e_wrap;
    logic [7:0] e_sat;
    logic       e_ovf;
    int         e_id;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  // Exact integer difference, then range test against the signed DW-bit range.
  task automatic model_result(input int a, input int b, output logic [7:0] d, output logic o);
    int full;
    full = a - b;
    o = (full > 127) || (full < -128);
`ifdef SSUB_ARB_SAT_EN
    d = !o ? 8'(full) : (full > 0 ? 8'h7F : 8'h80);
`else
    d = 8'(full);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ack"}, bus.ack, 0);
    check({tag, ".valid"}, bus.rsp_valid, 0);
    check({tag, ".diff"}, bus.diff_out, 0);
    check({tag, ".ovf"}, bus.ovf, 0);
    check({tag, ".id"}, bus.rsp_id, 0);
    check({tag, ".busy"}, bus.busy, 0);
  endtask

  // Called just after a falling edge with the DUT in IDLE; returns in IDLE after acceptance.
  task automatic run_txn(input logic [3:0] r, input logic [31:0] af, input logic [31:0] bf,
                         input int stall, input logic [3:0] e_ack, input logic [7:0] e_diff,
                         input logic e_ovf, input int e_id, input string tag);
    bus.req = r; bus.a_in = af; bus.b_in = bf; bus.rsp_ready = 1'b0;
    @(negedge Clk);
    check({tag, ".ack"}, bus.ack, e_ack);
    check({tag, ".busy"}, bus.busy, 1);
    check({tag, ".early_valid"}, bus.rsp_valid, 0);
    bus.req = '0;
    @(negedge Clk);
    check({tag, ".ack_pulse"}, bus.ack, 0);
    check({tag, ".valid"}, bus.rsp_valid, 1);
    check({tag, ".diff"}, bus.diff_out, e_diff);
    check({tag, ".ovf"}, bus.ovf, e_ovf);
    check({tag, ".id"}, bus.rsp_id, e_id);
    for (int s = 0; s < stall; s++) begin
      bus.req = 4'($urandom); bus.a_in = $urandom; bus.b_in = $urandom;
      @(negedge Clk);
      check({tag, ".hold_valid"}, bus.rsp_valid, 1);
      check({tag, ".hold_diff"}, bus.diff_out, e_diff);
      check({tag, ".hold_id"}, bus.rsp_id, e_id);
      check({tag, ".hold_noack"}, bus.ack, 0);
    end
    bus.req = '0; bus.rsp_ready = 1'b1;
    @(negedge Clk);
    bus.rsp_ready = 1'b0;
    check({tag, ".accepted"}, bus.rsp_valid, 0);
    check({tag, ".idle"}, bus.busy, 0);
    check({tag, ".diff_kept"}, bus.diff_out, e_diff);
    m_last = e_id;
  endtask

  task automatic reset_pulse();
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    m_last = NR - 1;
  endtask

  initial begin
    logic [3:0]  rr_exp [5];
    logic [31:0] af, bf;
    logic [7:0]  ed;
    logic        eo;
    logic [3:0]  r;
    int          w;

    vecs[0] = '{4'b0010, 8'h14, 8'h32, 0, 4'b0010, 8'hE2, 8'hE2, 1'b0, 1};
    vecs[1] = '{4'b1111, 8'h64, 8'h9C, 0, 4'b0100, 8'hC8, 8'h7F, 1'b1, 2};
    vecs[2] = '{4'b1011, 8'h80, 8'h01, 1, 4'b1000, 8'h7F, 8'h80, 1'b1, 3};
    vecs[3] = '{4'b0110, 8'h05, 8'h07, 0, 4'b0010, 8'hFE, 8'hFE, 1'b0, 1};
    vecs[4] = '{4'b0001, 8'hFF, 8'hFF, 5, 4'b0001, 8'h00, 8'h00, 1'b0, 0};
    vecs[5] = '{4'b1111, 8'h7F, 8'hFF, 0, 4'b0010, 8'h80, 8'h7F, 1'b1, 1};
    vecs[6] = '{4'b0101, 8'h9C, 8'h64, 2, 4'b0100, 8'h38, 8'h80, 1'b1, 2};
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset held with all requesters active.
    Rst = 1'b1; bus.req = 4'b1111; bus.a_in = {4{8'h11}}; bus.b_in = {4{8'h22}}; bus.rsp_ready = 1'b1;
    repeat (3) @(negedge Clk);
    check_all_zero("in_reset");
    Rst = 1'b0;
    run_txn(4'b1111, {4{8'h11}}, {4{8'h22}}, 0, 4'b0001, 8'hEF, 1'b0, 0, "post_reset");

    // Reset while EXEC: the aborted request never responds; last_id returns to NREQ-1.
    bus.req = 4'b0010; bus.a_in = {4{8'h30}}; bus.b_in = {4{8'h10}};
    @(negedge Clk);
    check("midrst.ack", bus.ack, 4'b0010);
    Rst = 1'b1;
    #1;
    check_all_zero("midrst.in_reset");
    @(negedge Clk);
    check("midrst.no_valid", bus.rsp_valid, 0);
    Rst = 1'b0;
    m_last = NR - 1;
    run_txn(4'b1111, {4{8'h30}}, {4{8'h10}}, 0, 4'b0001, 8'h20, 1'b0, 0, "midrst.next");

    reset_pulse();
    foreach (vecs[i]) begin
`ifdef SSUB_ARB_SAT_EN
      ed = vecs[i].e_sat;
`else
      ed = vecs[i].e_wrap;
`endif
      run_txn(vecs[i].req, {4{vecs[i].a}}, {4{vecs[i].b}}, vecs[i].stall,
              vecs[i].e_ack, ed, vecs[i].e_ovf, vecs[i].e_id, $sformatf("vec%0d", i));
    end

    // Round-robin with every requester held and the consumer always ready.
    reset_pulse();
    bus.req = 4'b1111; bus.a_in = {4{8'h05}}; bus.b_in = {4{8'h03}}; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check($sformatf("rr.ack%0d", i), bus.ack, rr_exp[i]);
      if (i == 4) bus.req = '0;
      for (int g = 0; g < 2; g++) begin
        @(negedge Clk);
        check($sformatf("rr.gap%0d", i), bus.ack, 0);
      end
    end
    bus.rsp_ready = 1'b0;
    m_last = 0;

    // Random traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(0, 15));
      if (r == 0) begin
        bus.req = '0;
        @(negedge Clk);
        check("rand.idle_noack", bus.ack, 0);
        check("rand.idle_busy", bus.busy, 0);
      end else begin
        af = $urandom; bf = $urandom;
        w  = model_winner(r, m_last);
        model_result(int'($signed(af[w*8 +: 8])), int'($signed(bf[w*8 +: 8])), ed, eo);
        run_txn(r, af, bf, $urandom_range(0, 3), 4'(1 << w), ed, eo, w, $sformatf("rand%0d", t));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ssub_arbiter.md
# ssub_arbiter

Round-robin arbiter and sequencer that shares one signed subtractor (diff = a - b) between NREQ requesters in the assignment-2 datapath. It samples requests, grants one requester, latches its operands, computes the registered signed difference with an overflow flag, and holds the result under a valid/ready handshake until the consumer accepts it. Downstream register and comparator blocks consume `diff_out` and `rsp_id`.

## Interface
- `DATAWIDTH`, default 8: operand and result width, two's complement, at least 2.
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, derived as clog2(NREQ) with a minimum of 1: requester index width. Not user-set.

Ports:
- `Clk` input 1: single clock, rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `req` input NREQ: request per requester. Operands must be stable while high.
- `a_in` input NREQ*DATAWIDTH: flattened minuends. Requester i uses bits [i*DATAWIDTH +: DATAWIDTH].
- `b_in` input NREQ*DATAWIDTH: flattened subtrahends, same packing as `a_in`.
- `ack` output NREQ: one-hot, one-cycle pulse marking the operands as captured.
- `rsp_valid` output 1: result valid.
- `rsp_ready` input 1: consumer accepts the result.
- `diff_out` output DATAWIDTH: signed result.
- `ovf` output 1: signed overflow occurred on this result.
- `rsp_id` output IDW: index of the requester that owns the result.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE**
  - If `req` is nonzero at a clock edge, pick the winner. Search starts at (`last_id`+1) mod NREQ and goes upward with wrap.
  - Latch the winner's a and b into `a_r` and `b_r`, and its index into `id_r`.
  - Set `ack` to the winner's one-hot for the next cycle only.
  - Go to EXEC.
  - If `req` is zero, stay in IDLE.
- **EXEC**
  - Compute the full-width result of `a_r` - `b_r`.
  - `ovf` = (sign(a) != sign(b)) && (sign(result) != sign(a)).
  - Register `diff_out`, `ovf` and `rsp_id` = `id_r`, and set `rsp_valid` = 1.
  - Go to RESP. `ack` is 0.
- **RESP**
  - Hold `rsp_valid`, `diff_out`, `ovf` and `rsp_id` stable.
  - At an edge where `rsp_ready` = 1: clear `rsp_valid`, set `last_id` = `id_r`, go to IDLE.
  - `diff_out`, `ovf` and `rsp_id` keep their last values after acceptance.
- `req` is ignored outside IDLE. A requester must deassert or change operands only after seeing its `ack`.
- `rsp_ready` is ignored outside RESP.
- Arithmetic is two's complement. The wrapping result is the low DATAWIDTH bits.
- **Reset values** (asynchronous, any state): state = IDLE, `ack` = 0, `rsp_valid` = 0, `diff_out` = 0, `ovf` = 0, `rsp_id` = 0, `busy` = 0, `last_id` = NREQ-1 (so requester 0 wins first).
- **Reset mid-operation:** the in-flight operation is discarded. No `ack` and no `rsp_valid` are produced for it.

## Timing
- Edge E0 samples `req` in IDLE. `ack` is high during cycle E0→E1.
- Edge E1 (EXEC) registers the result. `rsp_valid` is first high in cycle E1→E2.
- Latency from request sample to `rsp_valid` is 2 cycles.
- The earliest next sample is at the edge after the RESP handshake edge.
- Minimum issue interval is 3 cycles when `rsp_ready` is held at 1.
- A requester with `req` held sees its `ack` no later than 3·NREQ cycles plus consumer stall cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SSUB_ARB_SAT_EN`
  - **Defined:** on overflow, `diff_out` saturates. It becomes the maximum positive value (0111…1) when `a_r` ≥ 0, else the minimum negative value (1000…0).
  - **Undefined:** `diff_out` is the wrapped result.
- `ovf` is reported identically in both builds.
- Latency and handshake are unchanged by the macro.

## Test plan
- **Reset priority:** assert `Rst` during traffic, then release with `req` = 4'b1111.
  - While in reset, all outputs are 0.
  - The first `ack` is 4'b0001 and the first `rsp_id` is 0.
- **Single request:** requester 1 with a = 20, b = 50, `rsp_ready` = 1.
  - `ack` = 4'b0010 for one cycle.
  - Two cycles after the sample: `rsp_valid` = 1, `diff_out` = 8'hE2 (-30), `ovf` = 0, `rsp_id` = 1.
- **Overflow:** a = 100, b = -100.
  - `ovf` = 1. `diff_out` = 8'hC8 without the macro, 8'h7F with it.
  - a = -128, b = 1: `ovf` = 1. `diff_out` = 8'h7F without the macro, 8'h80 with it.
- **Round-robin:** `req` = 4'b1111 held, `rsp_ready` = 1.
  - `ack` sequence is 0001, 0010, 0100, 1000, 0001, at 3-cycle spacing.
- **Backpressure:** `rsp_ready` = 0 for 5 cycles in RESP while `req` and operands toggle.
  - `rsp_valid`, `diff_out` and `rsp_id` stay stable, and no `ack` is issued.
  - After `rsp_ready` = 1, IDLE is re-entered and the next winner is `rsp_id`+1.
- **Mid-operation reset:** pulse `Rst` during EXEC.
  - No `rsp_valid` for the aborted operation and all outputs are 0.
  - The next grant goes to requester 0.
